// File: rtl/btb_controller_pkg.sv
// Shared types for the LC-3b fetch-stage branch target buffer.
// Holds the word/index types, the per-entry metadata record and the counter update rule.
package btb_controller_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_c_index;
    typedef logic [11:0] lc3b_btb_tag;
    typedef logic [1:0]  lc3b_btb_ctr;

    localparam int          BTB_ENTRIES   = 8;
    localparam lc3b_btb_ctr BTB_CTR_INIT  = 2'b10;
    localparam lc3b_btb_ctr BTB_CTR_CLEAR = 2'b01;

    typedef struct packed {
        logic        valid;
        lc3b_btb_tag tag;
        lc3b_btb_ctr ctr;
    } btb_meta_t;

    typedef enum logic {
        ST_SWEEP,
        ST_IDLE
    } btb_state_e;

    // Two-bit saturating counter: 00 and 11 are sticky at their ends.
    function automatic lc3b_btb_ctr ctr_next(input lc3b_btb_ctr ctr, input logic taken);
        lc3b_btb_ctr result;
        result = ctr;
        if (taken) begin
            if (ctr != 2'b11) result = ctr + 2'd1;
        end else begin
            if (ctr != 2'b00) result = ctr - 2'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/btb_controller_if.sv
// Fetch-side bundle for the BTB controller: lookup, resolution update, flush and target-store port.
// master is the controller; slave is the fetch stage that owns the btb_array.
interface btb_controller_if;
    import btb_controller_pkg::*;

    lc3b_word    fetch_pc;
    logic        btb_hit;
    logic        pred_taken;
    lc3b_word    pred_target;

    logic        upd_valid;
    lc3b_word    upd_pc;
    logic        upd_taken;
    lc3b_word    upd_target;

    logic        flush;
    logic        busy;

    lc3b_c_index arr_rindex;
    lc3b_c_index arr_windex;
    logic        arr_write;
    lc3b_word    arr_datain;
    lc3b_word    arr_dataout;

    modport master (
        input  fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, flush, arr_dataout,
        output btb_hit, pred_taken, pred_target, busy,
               arr_rindex, arr_windex, arr_write, arr_datain
    );

    modport slave (
        output fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, flush, arr_dataout,
        input  btb_hit, pred_taken, pred_target, busy,
               arr_rindex, arr_windex, arr_write, arr_datain
    );

endinterface

// File: rtl/btb_controller_meta_array.sv
// Per-entry {valid, tag, counter} store: two combinational read ports (lookup, update),
// one synchronous write port and a synchronous clear port used by the invalidate sweep.
module btb_meta_array
    import btb_controller_pkg::*;
(
    input  logic        clk,
    input  lc3b_c_index lidx,
    output btb_meta_t   lentry,
    input  lc3b_c_index uidx,
    output btb_meta_t   uentry,
    input  logic        we,
    input  lc3b_c_index widx,
    input  btb_meta_t   wentry,
    input  logic        clr,
    input  lc3b_c_index cidx
);

    btb_meta_t mem [BTB_ENTRIES];

    // NOTE: the storage has no reset; the controller's post-reset sweep clears every
    // entry and masks all lookups until it finishes, so a reset here would only cost flops.
    always_ff @(posedge clk) begin
        if (clr) begin
            mem[cidx] <= '{valid: 1'b0, tag: '0, ctr: BTB_CTR_CLEAR};
        end else if (we) begin
            mem[widx] <= wentry;
        end
    end

    assign lentry = mem[lidx];
    assign uentry = mem[uidx];

endmodule

// File: rtl/btb_controller.sv
// LC-3b BTB controller: combinational lookup, one-stage registered update, and an 8-cycle
// invalidate sweep after reset or flush. The target store itself lives outside this block.
module btb_controller
    import btb_controller_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    btb_controller_if.master bus
);

    btb_state_e  state, state_next;
    lc3b_c_index cnt, cnt_next;
    logic        busy;

    logic        u_valid;
    logic        u_taken;
    lc3b_c_index u_idx;
    lc3b_btb_tag u_tag;
    lc3b_word    u_target;
    logic        u_hit;

    lc3b_c_index fetch_idx;
    lc3b_btb_tag fetch_tag;
    btb_meta_t   l_entry, u_entry;

    logic        meta_we;
    lc3b_c_index meta_widx;
    btb_meta_t   meta_wentry;
    logic        meta_clr;
    lc3b_c_index meta_cidx;

    logic        arr_write;
    lc3b_c_index arr_windex;
    lc3b_word    arr_datain;

    logic        lookup_hit;
    logic        unused_pc_lsb;

    assign fetch_idx     = bus.fetch_pc[3:1];
    assign fetch_tag     = bus.fetch_pc[15:4];
    assign unused_pc_lsb = bus.fetch_pc[0] ^ bus.upd_pc[0];

    btb_meta_array u_meta (
        .clk    (clk),
        .lidx   (fetch_idx),
        .lentry (l_entry),
        .uidx   (u_idx),
        .uentry (u_entry),
        .we     (meta_we),
        .widx   (meta_widx),
        .wentry (meta_wentry),
        .clr    (meta_clr),
        .cidx   (meta_cidx)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_SWEEP;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            ST_SWEEP: begin
                if (bus.flush) begin
                    cnt_next = '0;
                end else if (cnt == lc3b_c_index'(BTB_ENTRIES - 1)) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 3'd1;
                end
            end
            ST_IDLE: begin
                if (bus.flush) begin
                    state_next = ST_SWEEP;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_SWEEP;
                cnt_next   = '0;
            end
        endcase
    end

    // Update register U: flush and the sweep both discard whatever is pending or arriving.
    always_ff @(posedge clk) begin
        if (reset || busy || bus.flush) begin
            u_valid <= 1'b0;
        end else begin
            u_valid <= bus.upd_valid;
        end
        u_taken  <= bus.upd_taken;
        u_idx    <= bus.upd_pc[3:1];
        u_tag    <= bus.upd_pc[15:4];
        u_target <= bus.upd_target;
    end

    assign u_hit = u_entry.valid && (u_entry.tag == u_tag);

    always_comb begin
        busy        = 1'b0;
        arr_write   = 1'b0;
        arr_windex  = u_idx;
        arr_datain  = u_target;
        meta_we     = 1'b0;
        meta_widx   = u_idx;
        meta_wentry = '{valid: 1'b1, tag: u_tag, ctr: BTB_CTR_INIT};
        meta_clr    = 1'b0;
        meta_cidx   = cnt;
        unique case (state)
            ST_SWEEP: begin
                busy       = 1'b1;
                arr_write  = 1'b1;
                arr_windex = cnt;
                arr_datain = '0;
                meta_clr   = 1'b1;
            end
            ST_IDLE: begin
                if (u_valid && !bus.flush) begin
                    if (u_hit) begin
                        meta_we     = 1'b1;
                        meta_wentry = '{valid: 1'b1, tag: u_tag,
                                        ctr: ctr_next(u_entry.ctr, u_taken)};
                        arr_write   = u_taken;
                    end else if (u_taken) begin
                        // Miss and taken: allocate over whatever alias occupied the slot.
                        meta_we   = 1'b1;
                        arr_write = 1'b1;
                    end
                end
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    assign lookup_hit      = !busy && l_entry.valid && (l_entry.tag == fetch_tag);
    assign bus.btb_hit     = lookup_hit;
    assign bus.pred_taken  = lookup_hit && l_entry.ctr[1];
    assign bus.pred_target = (lookup_hit && l_entry.ctr[1]) ? bus.arr_dataout : '0;
    assign bus.busy        = busy;
    assign bus.arr_rindex  = fetch_idx;
    assign bus.arr_windex  = arr_windex;
    assign bus.arr_write   = arr_write;
    assign bus.arr_datain  = arr_datain;

endmodule

// File: tb/tb_btb_controller.sv
// Directed bench for btb_controller: a vector table for lookup/update behaviour plus
// hand-written sequences for reset, flush and mid-sweep flush. Models btb_array locally.
module tb_btb_controller;
    import btb_controller_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    btb_controller_if bus ();

    btb_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Target store model: combinational read, synchronous write.
    lc3b_word arr_mem [BTB_ENTRIES];
    always_ff @(posedge clk) begin
        if (bus.arr_write) arr_mem[bus.arr_windex] <= bus.arr_datain;
    end
    assign bus.arr_dataout = arr_mem[bus.arr_rindex];

    typedef struct {
        logic     uv;
        lc3b_word upc;
        logic     ut;
        lc3b_word utg;
        lc3b_word fpc;
        logic     hit;
        logic     pt;
        lc3b_word tgt;
        logic     aw;
        logic [2:0] wi;
        lc3b_word wd;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.upd_valid  = 1'b0;
        bus.upd_pc     = '0;
        bus.upd_taken  = 1'b0;
        bus.upd_target = '0;
        bus.flush      = 1'b0;
    endtask

    // Starts just after the edge that launches the sweep; returns at the negedge of the
    // first idle cycle.
    task automatic check_sweep(input string name);
        for (int i = 0; i < BTB_ENTRIES; i++) begin
            @(negedge clk);
            check({name, "_busy"},   32'(bus.busy), 32'd1);
            check({name, "_write"},  32'(bus.arr_write), 32'd1);
            check({name, "_windex"}, 32'(bus.arr_windex), 32'(i));
            check({name, "_datain"}, 32'(bus.arr_datain), 32'd0);
            check({name, "_hit"},    32'(bus.btb_hit), 32'd0);
            check({name, "_ptgt"},   32'(bus.pred_target), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check({name, "_done_busy"},  32'(bus.busy), 32'd0);
        check({name, "_done_write"}, 32'(bus.arr_write), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        lc3b_word pcs [5];
        pcs = '{16'h3012, 16'h5006, 16'h600A, 16'h7000, 16'h8000};

        //                uv   upc       ut   utg       fpc       hit  pt   tgt       aw   wi    wd
        vecs.push_back('{1'b1, 16'h3002, 1'b1, 16'h3040, 16'h3002, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000});
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h3002, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd1, 16'h3040});
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h3002, 1'b1, 1'b1, 16'h3040, 1'b0, 3'd0, 16'h0000});
        vecs.push_back('{1'b1, 16'h3002, 1'b0, 16'h0000, 16'h3002, 1'b1, 1'b1, 16'h3040, 1'b0, 3'd0, 16'h0000});
        vecs.push_back('{1'b1, 16'h3002, 1'b0, 16'h0000, 16'h3002, 1'b1, 1'b1, 16'h3040, 1'b0, 3'd0, 16'h0000});
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h3002, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000});
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h3002, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000});
        vecs.push_back('{1'b1, 16'h3002, 1'b1, 16'h3040, 16'h3002, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000});
        vecs.push_back('{1'b1, 16'h3002, 1'b1, 16'h3040, 16'h3002, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd1, 16'h3040});
        vecs.push_back('{1'b1, 16'h3002, 1'b1, 16'h3040, 16'h3002, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd1, 16'h3040});
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h3002, 1'b1, 1'b1, 16'h3040, 1'b1, 3'd1, 16'h3040});
        vecs.push_back('{1'b1, 16'h3002, 1'b1, 16'h3040, 16'h3002, 1'b1, 1'b1, 16'h3040, 1'b0, 3'd0, 16'h0000});
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h3002, 1'b1, 1'b1, 16'h3040, 1'b1, 3'd1, 16'h3040});
        vecs.push_back('{1'b1, 16'h3002, 1'b0, 16'h0000, 16'h3002, 1'b1, 1'b1, 16'h3040, 1'b0, 3'd0, 16'h0000});
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h3002, 1'b1, 1'b1, 16'h3040, 1'b0, 3'd0, 16'h0000});
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h3002, 1'b1, 1'b1, 16'h3040, 1'b0, 3'd0, 16'h0000});
        vecs.push_back('{1'b1, 16'h3012, 1'b1, 16'h3080, 16'h3002, 1'b1, 1'b1, 16'h3040, 1'b0, 3'd0, 16'h0000});
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h3002, 1'b1, 1'b1, 16'h3040, 1'b1, 3'd1, 16'h3080});
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h3002, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000});
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h3012, 1'b1, 1'b1, 16'h3080, 1'b0, 3'd0, 16'h0000});
        vecs.push_back('{1'b1, 16'h4004, 1'b0, 16'h0000, 16'h4004, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000});
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h4004, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000});
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h4004, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000});
        vecs.push_back('{1'b1, 16'h5006, 1'b1, 16'h5100, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000});
        vecs.push_back('{1'b1, 16'h600A, 1'b1, 16'h6200, 16'h5006, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd3, 16'h5100});
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h5006, 1'b1, 1'b1, 16'h5100, 1'b1, 3'd5, 16'h6200});
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h600A, 1'b1, 1'b1, 16'h6200, 1'b0, 3'd0, 16'h0000});

        // Reset: one cycle, then the full 8-cycle sweep.
        idle_inputs();
        bus.fetch_pc = 16'h3002;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_sweep("reset");
        @(posedge clk); #1;
        @(negedge clk);
        check("post_reset_hit", 32'(bus.btb_hit), 32'd0);
        @(posedge clk); #1;

        // Table: one row per cycle.
        for (int r = 0; r < vecs.size(); r++) begin
            bus.upd_valid  = vecs[r].uv;
            bus.upd_pc     = vecs[r].upc;
            bus.upd_taken  = vecs[r].ut;
            bus.upd_target = vecs[r].utg;
            bus.fetch_pc   = vecs[r].fpc;
            @(negedge clk);
            check($sformatf("row%0d_hit", r),   32'(bus.btb_hit),     32'(vecs[r].hit));
            check($sformatf("row%0d_pt", r),    32'(bus.pred_taken),  32'(vecs[r].pt));
            check($sformatf("row%0d_tgt", r),   32'(bus.pred_target), 32'(vecs[r].tgt));
            check($sformatf("row%0d_write", r), 32'(bus.arr_write),   32'(vecs[r].aw));
            if (vecs[r].aw) begin
                check($sformatf("row%0d_windex", r), 32'(bus.arr_windex), 32'(vecs[r].wi));
                check($sformatf("row%0d_datain", r), 32'(bus.arr_datain), 32'(vecs[r].wd));
            end
            @(posedge clk); #1;
        end
        idle_inputs();

        // Flush with upd_valid in the same cycle, while another update is pending in U.
        bus.upd_valid = 1'b1; bus.upd_pc = 16'h8000; bus.upd_taken = 1'b1; bus.upd_target = 16'h8800;
        bus.fetch_pc  = 16'h8000;
        @(negedge clk);
        check("pre_flush_write", 32'(bus.arr_write), 32'd0);
        @(posedge clk); #1;
        bus.flush = 1'b1;
        bus.upd_valid = 1'b1; bus.upd_pc = 16'h7000; bus.upd_taken = 1'b1; bus.upd_target = 16'h7700;
        @(negedge clk);
        check("flush_cycle_busy",  32'(bus.busy), 32'd0);
        check("flush_cycle_write", 32'(bus.arr_write), 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        bus.fetch_pc = 16'h3012;
        check_sweep("flush_upd");
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            bus.fetch_pc = pcs[k];
            @(negedge clk);
            check($sformatf("after_flush_hit_%0h", pcs[k]), 32'(bus.btb_hit), 32'd0);
            check($sformatf("after_flush_write_%0h", pcs[k]), 32'(bus.arr_write), 32'd0);
        end

        // Flush arriving at sweep count 5 restarts a full sweep; updates during it are ignored.
        @(posedge clk); #1;
        bus.upd_valid = 1'b1; bus.upd_pc = 16'h3002; bus.upd_taken = 1'b1; bus.upd_target = 16'h3040;
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
        bus.fetch_pc = 16'h3002;
        @(negedge clk);
        check("realloc_hit", 32'(bus.btb_hit), 32'd1);
        check("realloc_tgt", 32'(bus.pred_target), 32'h3040);
        @(posedge clk); #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("mid_busy",   32'(bus.busy), 32'd1);
            check("mid_windex", 32'(bus.arr_windex), 32'(i));
            if (i == 5) begin
                bus.flush = 1'b1;
                bus.upd_valid = 1'b1; bus.upd_pc = 16'h9000;
                bus.upd_taken = 1'b1; bus.upd_target = 16'h9900;
            end
            @(posedge clk); #1;
        end
        bus.flush = 1'b0;
        check_sweep("flush_mid");
        idle_inputs();
        @(posedge clk); #1;
        bus.fetch_pc = 16'h3002;
        @(negedge clk);
        check("mid_after_hit_3002", 32'(bus.btb_hit), 32'd0);
        @(posedge clk); #1;
        bus.fetch_pc = 16'h9000;
        @(negedge clk);
        check("mid_after_hit_9000", 32'(bus.btb_hit), 32'd0);
        check("mid_after_write",    32'(bus.arr_write), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
